mmio_cmd_queue: RTL and testbench
=================================

Name: mmio_cmd_queue

Overview:
- Responder side of the processor's memory-mapped output path.
- Captures processor stores to the command address into a FIFO. Hands them one at a time to the VGA/game-display logic over a valid/ready handshake.
- Exposes a status word the processor can load to check occupancy and overflow.
- Sits between the processor data-memory bus (wren, address_dmem, data) and the VGA controller's command input. Replaces the single-cycle, unbuffered output path.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CMD_ADDR, 32'd2000, store address that pushes a command.
- STATUS_ADDR, 32'd2001, load address returning status; store here clears overflow.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wren  in  1  processor data-memory write enable.
- address_dmem  in  32  processor data-memory address.
- data  in  32  processor store data.
- status_sel  out  1  high when address_dmem==STATUS_ADDR and wren==0; combinational; the wrapper muxes status_data onto q_dmem.
- status_data  out  32  {overflow, 31-CNT_W zeros, count}; combinational from registers.
- cmd_valid  out  1  head entry available.
- cmd_data  out  32  head entry; stable while cmd_valid && !cmd_ready.
- cmd_ready  in  1  consumer accepts head this cycle.
- overflow  out  1  sticky: a push was dropped while full.

Behaviour:
- Reset (async assert, sync-to-clock release): count=0, rd_ptr=wr_ptr=0, overflow=0, cmd_valid=0, cmd_data=0. Reset mid-operation discards all queued entries.
- push_req = wren && address_dmem==CMD_ADDR. Evaluated every cycle. Each cycle it holds is one push; no edge detection.
- pop = cmd_valid && cmd_ready.
- Storage: DEPTH x 32 register array. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- cmd_valid = (count != 0). cmd_data = mem[rd_ptr]; cmd_data is 0 when empty.
- Latency: a push in cycle N makes the entry visible at cmd_valid/cmd_data in cycle N+1. No combinational bypass.
- Empty, push only: count 0->1, cmd_valid rises next cycle.
- Full, push without pop: push dropped, overflow<=1, count stays DEPTH, memory unchanged.
- Full, push with pop in the same cycle: both accepted, count stays DEPTH, new entry written at the freed slot.
- Empty, pop: impossible because cmd_valid=0; cmd_ready is ignored.
- Push and pop both in a non-full, non-empty state: count unchanged, both pointers advance.
- wren && address_dmem==STATUS_ADDR: overflow<=0 next cycle. If a dropped push occurs in the same cycle, set takes priority over clear, so overflow stays 1.
- Stores and loads to any other address: no effect. status_sel=0 for stores to STATUS_ADDR.
- status_data reflects register values at the start of the cycle, so a load sees pre-update count.

Optional Feature:
- Macro MMIO_CMD_COALESCE_EN.
- Defined:
  - If push_req, the queue is non-empty, and data equals the most recently written entry, the push is silently discarded. Count and overflow are unchanged.
  - A last_written register (32 bits, reset 0) tracks the last accepted data.
  - When the queue is empty, every push is accepted, including a value equal to last_written.
- Undefined: every push_req is enqueued per the rules above; the last_written register does not exist.

Test Plan:
- Reset, then store 0x11, 0x22, 0x33 to 2000 in consecutive cycles with cmd_ready=0 -> cmd_valid=1 from cycle after first store, cmd_data=0x11, status load at 2001 returns 0x00000003.
- Raise cmd_ready for 3 cycles -> cmd_data sequence 0x11, 0x22, 0x33, then cmd_valid=0, status=0x00000000.
- Fill with DEPTH=8 entries 1..8, store 9 -> overflow=1, status=0x80000008, pops yield 1..8, value 9 never appears. Store to 2001 -> status=0x80000000 becomes 0x00000000.
- Full queue, store 0xAA with cmd_ready=1 same cycle -> overflow stays 0, count stays 8, 0xAA emerges as the 8th pop after.
- Push 5 entries, assert reset mid-stream asynchronously -> cmd_valid=0, count=0 immediately; new store 0x77 after release is the next cmd_data.
- With MMIO_CMD_COALESCE_EN: store 0x5, 0x5, 0x6 with cmd_ready=0 -> count=2, pops 0x5, 0x6. Without the macro -> count=3, pops 0x5, 0x5, 0x6.

Source files
------------

// File: rtl/mmio_cmd_queue.sv
// rtl/mmio_cmd_queue.sv - MMIO store-to-command FIFO with status word; optional MMIO_CMD_COALESCE_EN drops repeated pushes
module mmio_cmd_queue #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] CMD_ADDR    = 32'd2000,
    parameter logic [31:0] STATUS_ADDR = 32'd2001,
    parameter int          CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic        status_sel,
    output logic [31:0] status_data,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    input  logic        cmd_ready,
    output logic        overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push_req;
    logic             pop;
    logic             dup;
    logic             push_ok;
    logic             drop;
    logic             status_wr;

    assign full      = (count == CNT_W'(DEPTH));
    assign push_req  = wren && (address_dmem == CMD_ADDR);
    assign status_wr = wren && (address_dmem == STATUS_ADDR);
    assign pop       = cmd_valid && cmd_ready;

`ifdef MMIO_CMD_COALESCE_EN
    logic [31:0] last_written;

    // A repeat of the newest queued value is redundant while it still sits in the queue.
    assign dup = push_req && (count != '0) && (data == last_written);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_written <= '0;
        end else if (push_ok) begin
            last_written <= data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // When full, a simultaneous pop frees the slot that wr_ptr (== rd_ptr) points at.
    assign push_ok = push_req && !dup && (!full || pop);
    assign drop    = push_req && !dup && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= data;
        end
    end

    // Set wins over clear so a drop in the same cycle as a status store is not lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_wr) begin
            overflow <= 1'b0;
        end
    end

    assign cmd_valid   = (count != '0);
    assign cmd_data    = cmd_valid ? mem[rd_ptr] : 32'd0;
    assign status_sel  = !wren && (address_dmem == STATUS_ADDR);
    assign status_data = {overflow, {(31 - CNT_W){1'b0}}, count};

endmodule

// File: tb/tb_mmio_cmd_queue.sv
// tb/tb_mmio_cmd_queue.sv - randomized and directed bench for mmio_cmd_queue against a queue model
module tb_mmio_cmd_queue;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] CMD_ADDR    = 32'd2000;
    localparam logic [31:0] STATUS_ADDR = 32'd2001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0;
    logic [31:0] address_dmem = 32'd0;
    logic [31:0] data = 32'd0;
    logic        status_sel;
    logic [31:0] status_data;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready = 1'b0;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
`ifdef MMIO_CMD_COALESCE_EN
    logic [31:0] m_lw = 32'd0;
`endif

    mmio_cmd_queue #(.DEPTH(DEPTH), .CMD_ADDR(CMD_ADDR), .STATUS_ADDR(STATUS_ADDR)) dut (
        .clock(clock),
        .reset(reset),
        .wren(wren),
        .address_dmem(address_dmem),
        .data(data),
        .status_sel(status_sel),
        .status_data(status_data),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(q.size());
        s[31] = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] m_head();
        return (q.size() != 0) ? q[0] : 32'd0;
    endfunction

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clock);
        wren = w;
        address_dmem = a;
        data = d;
        cmd_ready = r;
        #1;
    endtask

    task automatic tick();
        bit pop, preq, dup, acc, clr;
        logic [31:0] d;
        d    = data;
        pop  = (q.size() != 0) && cmd_ready;
        preq = wren && (address_dmem == CMD_ADDR);
        clr  = wren && (address_dmem == STATUS_ADDR);
        dup  = 1'b0;
`ifdef MMIO_CMD_COALESCE_EN
        dup  = preq && (q.size() != 0) && (d == m_lw);
`endif
        acc  = preq && !dup && ((q.size() < DEPTH) || pop);
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(d);
`ifdef MMIO_CMD_COALESCE_EN
            m_lw = d;
`endif
        end
        if (clr) m_ovf = 1'b0;
        if (preq && !dup && !acc) m_ovf = 1'b1;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic r);
        drive(1'b1, a, d, r);
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        tests++;
        if (cmd_valid !== 1'b0 || cmd_data !== 32'd0 || overflow !== 1'b0 || status_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b data=%h ovf=%b status=%h, required 0/0/0/0", cmd_valid, cmd_data, overflow, status_data);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (cmd_valid !== 1'b0 || status_sel !== 1'b1 || status_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_release: valid=%b sel=%b status=%h, required 0/1/00000000", cmd_valid, status_sel, status_data);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp = '{32'h11, 32'h22, 32'h33};
        store(CMD_ADDR, 32'h11, 1'b0);
        drive(1'b1, CMD_ADDR, 32'h22, 1'b0);
        tests++;
        if (cmd_valid !== 1'b1 || cmd_data !== 32'h11) begin
            fails++;
            $display("FAIL basic_first_visible: valid=%b data=%h, required 1/00000011", cmd_valid, cmd_data);
        end
        tick();
        store(CMD_ADDR, 32'h33, 1'b0);
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (status_sel !== 1'b1 || status_data !== 32'h3 || cmd_data !== 32'h11) begin
            fails++;
            $display("FAIL basic_status: sel=%b status=%h head=%h, required 1/00000003/00000011", status_sel, status_data, cmd_data);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            tests++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp[i]) begin
                fails++;
                $display("FAIL basic_pop%0d: valid=%b data=%h, required 1/%h", i, cmd_valid, cmd_data, exp[i]);
            end
            tick();
        end
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (cmd_valid !== 1'b0 || cmd_data !== 32'd0 || status_data !== 32'd0) begin
            fails++;
            $display("FAIL basic_drained: valid=%b data=%h status=%h, required 0/00000000/00000000", cmd_valid, cmd_data, status_data);
        end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) store(CMD_ADDR, 32'(i), 1'b0);
        store(CMD_ADDR, 32'd9, 1'b0);
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (overflow !== 1'b1 || status_data !== 32'h80000008) begin
            fails++;
            $display("FAIL overflow_set: ovf=%b status=%h, required 1/80000008", overflow, status_data);
        end
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            tests++;
            if (cmd_valid !== 1'b1 || cmd_data !== 32'(i)) begin
                fails++;
                $display("FAIL overflow_pop%0d: valid=%b data=%h, required 1/%h", i, cmd_valid, cmd_data, 32'(i));
            end
            tick();
        end
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (cmd_valid !== 1'b0 || status_data !== 32'h80000000) begin
            fails++;
            $display("FAIL overflow_sticky: valid=%b status=%h, required 0/80000000", cmd_valid, status_data);
        end
        tick();
        drive(1'b1, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (status_sel !== 1'b0) begin
            fails++;
            $display("FAIL status_sel_on_store: sel=%b, required 0", status_sel);
        end
        tick();
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (overflow !== 1'b0 || status_data !== 32'd0) begin
            fails++;
            $display("FAIL overflow_clear: ovf=%b status=%h, required 0/00000000", overflow, status_data);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [8];
        exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hAA};
        for (int i = 1; i <= 8; i++) store(CMD_ADDR, 32'(i), 1'b0);
        store(CMD_ADDR, 32'hAA, 1'b1);
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (overflow !== 1'b0 || status_data !== 32'h8) begin
            fails++;
            $display("FAIL full_push_pop_status: ovf=%b status=%h, required 0/00000008", overflow, status_data);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            tests++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp[i]) begin
                fails++;
                $display("FAIL full_push_pop_pop%0d: valid=%b data=%h, required 1/%h", i, cmd_valid, cmd_data, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) store(CMD_ADDR, 32'h40 + 32'(i), 1'b0);
        @(negedge clock);
        wren = 1'b0;
        cmd_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        tests++;
        if (cmd_valid !== 1'b0 || status_data !== 32'd0 || cmd_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_async: valid=%b status=%h data=%h, required 0/00000000/00000000", cmd_valid, status_data, cmd_data);
        end
        q.delete();
        m_ovf = 1'b0;
`ifdef MMIO_CMD_COALESCE_EN
        m_lw = 32'd0;
`endif
        @(negedge clock);
        reset = 1'b0;
        store(CMD_ADDR, 32'h77, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        tests++;
        if (cmd_valid !== 1'b1 || cmd_data !== 32'h77 || status_data !== 32'h1) begin
            fails++;
            $display("FAIL reset_mid_after: valid=%b data=%h status=%h, required 1/00000077/00000001", cmd_valid, cmd_data, status_data);
        end
        tick();
    endtask

    task automatic test_coalesce();
        logic [31:0] exp [3];
        int n;
`ifdef MMIO_CMD_COALESCE_EN
        exp = '{32'h5, 32'h6, 32'h0};
        n = 2;
`else
        exp = '{32'h5, 32'h5, 32'h6};
        n = 3;
`endif
        store(CMD_ADDR, 32'h5, 1'b0);
        store(CMD_ADDR, 32'h5, 1'b0);
        store(CMD_ADDR, 32'h6, 1'b0);
        drive(1'b0, STATUS_ADDR, 32'd0, 1'b0);
        tests++;
        if (status_data !== 32'(n)) begin
            fails++;
            $display("FAIL coalesce_count: status=%h, required %h", status_data, 32'(n));
        end
        tick();
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            tests++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp[i]) begin
                fails++;
                $display("FAIL coalesce_pop%0d: valid=%b data=%h, required 1/%h", i, cmd_valid, cmd_data, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int sel;
        logic w;
        logic [31:0] a, d;
        for (int c = 0; c < 600; c++) begin
            sel = $urandom_range(0, 19);
            w = ($urandom_range(0, 3) != 0);
            if (sel < 10)      a = CMD_ADDR;
            else if (sel < 12) a = STATUS_ADDR;
            else if (sel < 14) a = 32'd2002;
            else               a = $urandom;
            d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            drive(w, a, d, ($urandom_range(0, 9) < 3));
            tests++;
            if (cmd_valid !== (q.size() != 0) || cmd_data !== m_head()) begin
                fails++;
                $display("FAIL random_head c=%0d: valid=%b data=%h, required %b/%h", c, cmd_valid, cmd_data, (q.size() != 0), m_head());
            end
            tests++;
            if (status_data !== m_status() || overflow !== m_ovf) begin
                fails++;
                $display("FAIL random_status c=%0d: status=%h ovf=%b, required %h/%b", c, status_data, overflow, m_status(), m_ovf);
            end
            tests++;
            if (status_sel !== (!w && a == STATUS_ADDR)) begin
                fails++;
                $display("FAIL random_status_sel c=%0d: sel=%b, required %b", c, status_sel, (!w && a == STATUS_ADDR));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_coalesce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
